// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: serial subtractor FSM encodings and default width.
package arith_pkg;

  localparam int ARITH_W = 8;

  typedef enum logic [1:0] {
    SS_IDLE  = 2'd0,
    SS_SHIFT = 2'd1,
    SS_DONE  = 2'd2
  } ss_state_e;

endpackage

// File: rtl/full_sub_cell.sv
// Full subtractor bit cell built from two half subtractors and an OR of their borrows.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1_s;
  logic b1_s;
  logic b2_s;

  half_sub u_hs0 (.a(a),    .b(b),   .d(d1_s), .bo(b1_s));
  half_sub u_hs1 (.a(d1_s), .b(bin), .d(d),    .bo(b2_s));

  assign bout = b1_s | b2_s;

endmodule

// File: rtl/half_sub.sv
// Half subtractor: d = a - b for single bits, bo is the borrow out.
module half_sub (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);

  assign d  = a ^ b;
  assign bo = ~a & b;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full_sub_cell.
// Optional signed-overflow output ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dif,
  output logic             bo
`ifdef SERIAL_SUB_OVF_EN
  , output logic           ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  ss_state_e        state_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-2:0] res_r;
  logic [WIDTH-1:0] dif_r;
  logic             br_r;
  logic             bo_r;
  logic             busy_r;
  logic             done_r;
  logic             d_s;
  logic             bout_s;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_r;
`endif

  full_sub_cell u_cell (
    .a   (a_sr_r[0]),
    .b   (b_sr_r[0]),
    .bin (br_r),
    .d   (d_s),
    .bout(bout_s)
  );

  // FSM, operand/result shifting, borrow flop and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SS_IDLE;
      count_r <= {CW{1'b0}};
      a_sr_r  <= {WIDTH{1'b0}};
      b_sr_r  <= {WIDTH{1'b0}};
      res_r   <= {(WIDTH-1){1'b0}};
      dif_r   <= {WIDTH{1'b0}};
      br_r    <= 1'b0;
      bo_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        SS_IDLE, SS_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= SS_SHIFT;
            a_sr_r  <= a;
            b_sr_r  <= b;
            br_r    <= 1'b0;
            count_r <= {CW{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            state_r <= SS_IDLE;
            busy_r  <= 1'b0;
          end
        end
        SS_SHIFT: begin
          a_sr_r <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r <= {1'b0, b_sr_r[WIDTH-1:1]};
          br_r   <= bout_s;
          res_r  <= (WIDTH-1)'({d_s, res_r} >> 1);
          if (count_r == CW'(WIDTH-1)) begin
            // Last bit: the cell is looking at the operand MSBs right now
            state_r <= SS_DONE;
            count_r <= {CW{1'b0}};
            dif_r   <= {d_s, res_r};
            bo_r    <= bout_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r   <= (a_sr_r[0] ^ b_sr_r[0]) & (a_sr_r[0] ^ d_s);
`endif
          end else begin
            count_r <= count_r + CW'(1);
          end
        end
        default: begin
          state_r <= SS_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign dif  = dif_r;
  assign bo   = bo_r;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_r;
`endif

endmodule
